// File: rtl/laser_dose_monitor.sv
// Independent pulse-dose monitor beside the laser controller: measures each light pulse,
// counts good pulses and latches a sticky fault with cause code and a registered kill line.
module laser_dose_monitor #(
  parameter int NBITS       = 32,
  parameter int EXPECT_ON   = 25000000,
  parameter int TOL         = 2,
  parameter int MAX_REQ_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             b,
  input  logic             light,
  input  logic             clear,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic             kill,
  output logic             done,
  output logic [NBITS-1:0] last_width,
  output logic [7:0]       pulse_cnt
);

  localparam int LATW = $clog2(MAX_REQ_LAT + 1);

  localparam logic [LATW-1:0]  LAT_LIMIT = LATW'(MAX_REQ_LAT);
  localparam logic [LATW-1:0]  LAT_ONE   = LATW'(1);
  localparam logic [LATW-1:0]  LAT_ZERO  = LATW'(0);
  localparam logic [NBITS-1:0] W_ONE     = NBITS'(1);
  localparam logic [NBITS-1:0] W_LO      = NBITS'(EXPECT_ON - TOL);
  localparam logic [NBITS-1:0] W_HI      = NBITS'(EXPECT_ON + TOL);
  localparam logic [NBITS-1:0] W_OVER    = NBITS'(EXPECT_ON + TOL + 1);

  localparam logic [1:0] CODE_SHORT  = 2'b00;
  localparam logic [1:0] CODE_SPUR   = 2'b01;
  localparam logic [1:0] CODE_NORESP = 2'b10;
  localparam logic [1:0] CODE_LONG   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_ON    = 2'b10,
    ST_FAULT = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] width_q, width_d;
  logic [LATW-1:0]  lat_cnt_q, lat_cnt_d;
  logic [LATW-1:0]  lat_next_s;
  logic             fault_q, fault_d;
  logic [1:0]       code_q, code_d;
  logic             kill_q, kill_d;
  logic             done_q, done_d;
  logic [NBITS-1:0] last_width_q, last_width_d;
  logic [7:0]       pulse_cnt_q, pulse_cnt_d;

  // Next-state and next-output computation for the monitor FSM.
  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    lat_cnt_d    = lat_cnt_q;
    code_d       = code_q;
    done_d       = 1'b0;
    last_width_d = last_width_q;
    pulse_cnt_d  = pulse_cnt_q;
    lat_next_s   = lat_cnt_q + LAT_ONE;

    case (state_q)
      ST_IDLE: begin
        // Light without a request outranks a simultaneous request.
        if (light) begin
          state_d = ST_FAULT;
          code_d  = CODE_SPUR;
        end else if (b) begin
          state_d   = ST_ARMED;
          lat_cnt_d = LAT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ARMED: begin
        if (light) begin
          state_d = ST_ON;
          width_d = W_ONE;
        end else if (lat_next_s == LAT_LIMIT) begin
          state_d   = ST_FAULT;
          code_d    = CODE_NORESP;
          lat_cnt_d = lat_next_s;
        end else begin
          lat_cnt_d = lat_next_s;
        end
      end

      ST_ON: begin
        if (light) begin
          if (width_q == W_HI) begin
            state_d      = ST_FAULT;
            code_d       = CODE_LONG;
            last_width_d = W_OVER;
          end else begin
            width_d = width_q + W_ONE;
          end
        end else begin
          last_width_d = width_q;
          if ((width_q >= W_LO) && (width_q <= W_HI)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (pulse_cnt_q != 8'hFF) begin
              pulse_cnt_d = pulse_cnt_q + 8'd1;
            end else begin
              pulse_cnt_d = pulse_cnt_q;
            end
          end else begin
            state_d = ST_FAULT;
            code_d  = CODE_SHORT;
          end
        end
      end

      ST_FAULT: begin
        // Leave only once the laser is seen off while acknowledged; first cause is held.
        if (clear && !light) begin
          state_d = ST_IDLE;
          code_d  = 2'b00;
        end else begin
          state_d = ST_FAULT;
        end
      end

      default: begin
        state_d = ST_FAULT;
        code_d  = CODE_SPUR;
      end
    endcase

    fault_d = (state_d == ST_FAULT);
    kill_d  = (state_d == ST_FAULT);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      width_q      <= {NBITS{1'b0}};
      lat_cnt_q    <= LAT_ZERO;
      fault_q      <= 1'b0;
      code_q       <= 2'b00;
      kill_q       <= 1'b0;
      done_q       <= 1'b0;
      last_width_q <= {NBITS{1'b0}};
      pulse_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      lat_cnt_q    <= lat_cnt_d;
      fault_q      <= fault_d;
      code_q       <= code_d;
      kill_q       <= kill_d;
      done_q       <= done_d;
      last_width_q <= last_width_d;
      pulse_cnt_q  <= pulse_cnt_d;
    end
  end

  assign fault      = fault_q;
  assign fault_code = code_q;
  assign kill       = kill_q;
  assign done       = done_q;
  assign last_width = last_width_q;
  assign pulse_cnt  = pulse_cnt_q;

endmodule

// File: tb/tb_laser_dose_monitor.sv
// Scoreboard bench for laser_dose_monitor: expected pulse outcomes are queued as stimulus
// is driven and compared when the monitor reports done or a new fault.
module tb_laser_dose_monitor;

  localparam int NB     = 32;
  localparam int EXP_ON = 10;
  localparam int TOLC   = 2;
  localparam int MAXLAT = 4;
  localparam int W_LO   = EXP_ON - TOLC;
  localparam int W_HI   = EXP_ON + TOLC;

  logic          clk = 1'b0;
  logic          reset;
  logic          b;
  logic          light;
  logic          clear;
  logic          fault;
  logic [1:0]    fault_code;
  logic          kill;
  logic          done;
  logic [NB-1:0] last_width;
  logic [7:0]    pulse_cnt;

  typedef struct {
    logic        is_fault;
    logic [1:0]  code;
    logic [31:0] width;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_cnt  = 0;
  int   exp_last = 0;

  laser_dose_monitor #(
    .NBITS(NB), .EXPECT_ON(EXP_ON), .TOL(TOLC), .MAX_REQ_LAT(MAXLAT)
  ) dut (
    .clk(clk), .reset(reset), .b(b), .light(light), .clear(clear),
    .fault(fault), .fault_code(fault_code), .kill(kill), .done(done),
    .last_width(last_width), .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic f, input logic [1:0] c, input int w, input int cnt);
    exp_t e;
    e.is_fault = f;
    e.code     = c;
    e.width    = 32'(w);
    e.cnt      = 8'(cnt);
    sb_q.push_back(e);
  endtask

  // Request, `gap` low samples in ARMED, then `w` high samples of light, then light low.
  task automatic do_pulse(input int gap, input int w);
    if (w >= W_LO && w <= W_HI) begin
      exp_cnt  = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
      exp_last = w;
      push_exp(1'b0, 2'b00, w, exp_cnt);
    end else if (w < W_LO) begin
      exp_last = w;
      push_exp(1'b1, 2'b00, w, exp_cnt);
    end else begin
      exp_last = W_HI + 1;
      push_exp(1'b1, 2'b11, W_HI + 1, exp_cnt);
    end
    b = 1'b1;
    step(1);
    b = 1'b0;
    if (gap > 0) step(gap);
    light = 1'b1;
    if (w <= W_HI) begin
      step(w);
      light = 1'b0;
      step(1);
    end else begin
      step(W_HI);
      check_eq("long_before_limit", 32'(fault), 32'd0);
      step(1);
      check_eq("long_at_limit", 32'(fault), 32'd1);
      if (w > W_HI + 1) step(w - W_HI - 1);
      light = 1'b0;
      step(1);
    end
  endtask

  task automatic drain(input string tag);
    step(1);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step(1);
    check_eq(tag, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic clear_fault(input string tag);
    light = 1'b0;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_eq({tag, "_fault_cleared"}, 32'(fault), 32'd0);
    check_eq({tag, "_kill_cleared"}, 32'(kill), 32'd0);
    check_eq({tag, "_code_cleared"}, 32'(fault_code), 32'd0);
  endtask

  // Output monitor: every done pulse or new fault consumes one scoreboard entry.
  initial begin
    logic fault_prev;
    exp_t e;
    fault_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || (fault === 1'b1 && fault_prev === 1'b0)) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_event", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check_eq("evt_fault", 32'(fault), 32'(e.is_fault));
          check_eq("evt_done", 32'(done), 32'(!e.is_fault));
          check_eq("evt_kill", 32'(kill), 32'(e.is_fault));
          if (e.is_fault) check_eq("evt_code", 32'(fault_code), 32'(e.code));
          check_eq("evt_last_width", last_width, e.width);
          check_eq("evt_pulse_cnt", 32'(pulse_cnt), 32'(e.cnt));
        end
      end
      fault_prev = fault;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    b     = 1'b0;
    light = 1'b0;
    clear = 1'b0;
    step(2);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_code", 32'(fault_code), 32'd0);
    check_eq("rst_kill", 32'(kill), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_last_width", last_width, 32'd0);
    check_eq("rst_pulse_cnt", 32'(pulse_cnt), 32'd0);
    reset = 1'b1;
    step(1);

    // Good pulses at nominal, lower and upper bound widths.
    do_pulse(1, 10);
    step(1);
    check_eq("done_one_cycle", 32'(done), 32'd0);
    do_pulse(1, 8);
    step(1);
    do_pulse(1, 12);
    step(1);
    check_eq("cnt_after_three", 32'(pulse_cnt), 32'd3);
    check_eq("no_fault_after_good", 32'(fault), 32'd0);
    drain("drain_good");

    // Short pulse, then over-length pulse.
    do_pulse(1, 7);
    check_eq("short_kill", 32'(kill), 32'd1);
    drain("drain_short");
    clear_fault("short");
    do_pulse(1, 15);
    drain("drain_long");
    clear_fault("long");

    // No response: fault on the 4th low sample in ARMED.
    push_exp(1'b1, 2'b10, exp_last, exp_cnt);
    b = 1'b1;
    step(1);
    b = 1'b0;
    step(MAXLAT - 1);
    check_eq("noresp_before_limit", 32'(fault), 32'd0);
    step(1);
    check_eq("noresp_at_limit", 32'(fault), 32'd1);
    drain("drain_noresp");
    clear_fault("noresp");
    do_pulse(MAXLAT - 1, 10);
    drain("drain_late_light");

    // Spurious light, clear ignored while light is on.
    push_exp(1'b1, 2'b01, exp_last, exp_cnt);
    light = 1'b1;
    step(1);
    clear = 1'b1;
    step(2);
    check_eq("clear_while_light_fault", 32'(fault), 32'd1);
    check_eq("clear_while_light_kill", 32'(kill), 32'd1);
    check_eq("clear_while_light_code", 32'(fault_code), 32'd1);
    light = 1'b0;
    step(1);
    clear = 1'b0;
    check_eq("spur_exit_fault", 32'(fault), 32'd0);
    check_eq("spur_exit_kill", 32'(kill), 32'd0);
    drain("drain_spur");
    push_exp(1'b1, 2'b01, exp_last, exp_cnt);
    b     = 1'b1;
    light = 1'b1;
    step(1);
    b = 1'b0;
    drain("drain_spur_with_req");
    clear_fault("spur_with_req");

    // Reset in the middle of a pulse; light still on after release.
    b = 1'b1;
    step(1);
    b = 1'b0;
    step(1);
    light = 1'b1;
    step(5);
    reset = 1'b0;
    #1;
    check_eq("midrst_fault", 32'(fault), 32'd0);
    check_eq("midrst_kill", 32'(kill), 32'd0);
    check_eq("midrst_code", 32'(fault_code), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_last_width", last_width, 32'd0);
    check_eq("midrst_pulse_cnt", 32'(pulse_cnt), 32'd0);
    step(1);
    exp_cnt  = 0;
    exp_last = 0;
    push_exp(1'b1, 2'b01, exp_last, exp_cnt);
    reset = 1'b1;
    step(1);
    drain("drain_midrst");
    clear_fault("midrst");

    // Back-to-back good pulses until the counter saturates.
    for (int i = 0; i < 256; i++) do_pulse(i % 3, 10);
    step(1);
    check_eq("pulse_cnt_saturated", 32'(pulse_cnt), 32'd255);
    drain("drain_saturation");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
